// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit scan, one-cycle anode dead-time,
// per-digit blinking and a shadow/active double buffer that only swaps at frame wrap.
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [5*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [4:0]          GLYPH_BLANK = 5'h10;
  localparam logic [5*DIGITS-1:0] ALL_BLANK   = {DIGITS{GLYPH_BLANK}};

  logic [CW-1:0]       cnt;
  logic [DW-1:0]       dig;
  logic [BW-1:0]       bcnt;
  logic                phase;
  logic                pend;
  logic [5*DIGITS-1:0] active_code, shadow_code;
  logic [DIGITS-1:0]   active_mask, shadow_mask;

  logic slot_end, wrap;

  assign slot_end = (cnt == CW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (dig == DW'(DIGITS - 1));

  // Scan position: prescaler and digit index.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dig <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= wrap ? '0 : dig + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer: a load on the wrap cycle bypasses the shadow straight into active.
  // NOTE: the glyph buffers are plain registers, so they are reset to blank like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_code <= ALL_BLANK;
      shadow_mask <= '0;
      active_code <= ALL_BLANK;
      active_mask <= '0;
      pend        <= 1'b0;
    end else begin
      if (load) begin
        shadow_code <= data;
        shadow_mask <= blink_mask;
      end
      if (wrap) begin
        pend <= 1'b0;
        if (load) begin
          active_code <= data;
          active_mask <= blink_mask;
        end else if (pend) begin
          active_code <= shadow_code;
          active_mask <= shadow_mask;
        end
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  // Blink phase advances only on frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (bcnt == BW'(BLINK_FRAMES - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'h00:   decode = 7'b1111110;
      5'h01:   decode = 7'b0110000;
      5'h02:   decode = 7'b1101101;
      5'h03:   decode = 7'b1111001;
      5'h04:   decode = 7'b0110011;
      5'h05:   decode = 7'b1011011;
      5'h06:   decode = 7'b1011111;
      5'h07:   decode = 7'b1110000;
      5'h08:   decode = 7'b1111111;
      5'h09:   decode = 7'b1111011;
      5'h0A:   decode = 7'b1110111;
      5'h0B:   decode = 7'b0011111;
      5'h0C:   decode = 7'b1001110;
      5'h0D:   decode = 7'b0111101;
      5'h0E:   decode = 7'b1001111;
      5'h0F:   decode = 7'b1000111;
      5'h11:   decode = 7'b0000001;
      default: decode = 7'b0000000;
    endcase
  endfunction

  logic [6:0]        seg_raw;
  logic [DIGITS-1:0] an_raw;
  logic [4:0]        cur_code;
  logic              hidden;

  // Outputs depend on registered state only; cnt==0 is the dead-time cycle of every slot.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seg_raw  = 7'b0000000;
    an_raw   = '0;
    cur_code = active_code[5*dig +: 5];
    hidden   = active_mask[dig] & phase;
    if (cnt != '0) begin
      an_raw = DIGITS'(1) << dig;
      if (!hidden) seg_raw = decode(cur_code);
    end
  end

  assign seg        = ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign an         = ACTIVE_LOW ? ~an_raw  : an_raw;
  assign frame_tick = (dig == '0) && (cnt == '0);
  assign pending    = pend;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=0).
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [19:0] data;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  int tests = 0;
  int fails = 0;

  logic [6:0] sb [$];

  logic [6:0] glyph_exp [32] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
    7'b0000000, 7'b0000001, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .blink_mask(blink_mask),
    .seg(seg), .an(an), .frame_tick(frame_tick), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next frame_tick cycle, bounded.
  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: frame_tick not seen within 40 cycles", name);
    end
  endtask

  // Called in the frame_tick cycle; checks every slot of the frame against the scoreboard.
  task automatic observe_frame(input string name);
    logic [6:0] e;
    logic [3:0] ea;
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL %s: scoreboard empty at digit %0d", name, d);
        e = 7'bx;
      end else begin
        e = sb.pop_front();
      end
      ea = 4'b0001 << d;
      for (int c = 1; c < 4; c++) begin
        @(negedge clk);
        tests++;
        if (an !== ea || seg !== e) begin
          fails++;
          $display("FAIL %s digit%0d cyc%0d: an=%b seg=%b, required an=%b seg=%b",
                   name, d, c, an, seg, ea, e);
        end
      end
      if (d < 3) begin
        @(negedge clk);
        tests++;
        if (an !== 4'b0000 || seg !== 7'b0000000) begin
          fails++;
          $display("FAIL %s deadtime%0d: an=%b seg=%b, required 0000/0000000", name, d, an, seg);
        end
      end
    end
  endtask

  task automatic check_pending(input string name, input logic exp);
    tests++;
    if (pending !== exp) begin
      fails++;
      $display("FAIL %s: pending=%b, required %b", name, pending, exp);
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    rst = 1'b1; load = 1'b0; data = '0; blink_mask = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (an !== 4'b0000 || seg !== 7'b0000000 || pending !== 1'b0 || frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: an=%b seg=%b pending=%b tick=%b, required 0000/0000000/0/1",
               an, seg, pending, frame_tick);
    end
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      ea = (i % 4 == 0) ? 4'b0000 : (4'b0001 << ((i / 4) % 4));
      tests++;
      if (an !== ea || frame_tick !== (i % 16 == 0)) begin
        fails++;
        $display("FAIL scan_seq cyc%0d: an=%b tick=%b, required an=%b tick=%b",
                 i, an, frame_tick, ea, (i % 16 == 0));
      end
    end
  endtask

  task automatic test_decode();
    for (int g = 0; g < 8; g++) begin
      wait_tick("decode_sync");
      @(negedge clk);
      data = {5'(4*g+3), 5'(4*g+2), 5'(4*g+1), 5'(4*g)};
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int d = 0; d < 4; d++) sb.push_back(glyph_exp[4*g+d]);
      wait_tick("decode_wrap");
      observe_frame("decode");
    end
  endtask

  task automatic test_load();
    wait_tick("load_sync");
    repeat (5) @(negedge clk);
    data = {5'h0F, 5'h11, 5'h09, 5'h00};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_pending("load_pend_rise", 1'b1);
    repeat (9) @(negedge clk);
    check_pending("load_pend_hold", 1'b1);
    sb.push_back(7'b1111110); sb.push_back(7'b1111011);
    sb.push_back(7'b0000001); sb.push_back(7'b1000111);
    wait_tick("load_wrap");
    observe_frame("load");
    check_pending("load_pend_fall", 1'b0);
  endtask

  task automatic test_double_load();
    wait_tick("dbl_sync");
    repeat (2) @(negedge clk);
    data = {4{5'h01}};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    data = {4{5'h08}};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) sb.push_back(7'b1111111);
    wait_tick("dbl_wrap");
    observe_frame("double_load");
  endtask

  task automatic test_load_on_wrap();
    wait_tick("wrap_sync");
    repeat (15) @(negedge clk);
    data = {5'h0A, 5'h0B, 5'h12, 5'h06};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL wrap_align: frame_tick=%b, required 1", frame_tick);
    end
    check_pending("wrap_pend_tick", 1'b0);
    sb.push_back(7'b1011111); sb.push_back(7'b0000000);
    sb.push_back(7'b0011111); sb.push_back(7'b1110111);
    observe_frame("load_on_wrap");
    check_pending("wrap_pend_after", 1'b0);
  endtask

  task automatic test_blink();
    logic [6:0] d0 [5] = '{7'b1111111, 7'b0000000, 7'b0000000, 7'b1111111, 7'b1111111};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    data = {4{5'h08}};
    blink_mask = 4'b0001;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    blink_mask = 4'b0000;
    for (int f = 0; f < 5; f++) begin
      sb.push_back(d0[f]);
      repeat (3) sb.push_back(7'b1111111);
      wait_tick("blink_wrap");
      observe_frame("blink");
    end
  endtask

  task automatic test_reset_mid();
    wait_tick("rmid_sync");
    data = {4{5'h03}};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_pending("rmid_pend", 1'b1);
    repeat (8) @(negedge clk);
    tests++;
    if (an !== 4'b0100) begin
      fails++;
      $display("FAIL rmid_pos: an=%b, required 0100", an);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (an !== 4'b0000 || seg !== 7'b0000000 || pending !== 1'b0 || frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL rmid_async: an=%b seg=%b pending=%b tick=%b, required 0000/0000000/0/1",
               an, seg, pending, frame_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) sb.push_back(7'b0000000);
    wait_tick("rmid_wrap");
    observe_frame("reset_mid");
    check_pending("rmid_pend_after", 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load();
    test_double_load();
    test_load_on_wrap();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
